// File: rtl/rv_iopmp_entry_arbiter.sv
// rv_iopmp_entry_arbiter: shares one single-port entry SRAM between the
// register-map (cfg) port and the matching-logic (match) port. Grants are
// combinational, read latency is one cycle, and a burst limiter keeps cfg
// from starving match. An in-range cfg write pulses match_restart_o.
module rv_iopmp_entry_arbiter #(
  parameter int NUMBER_ENTRIES = 8,
  parameter int ENTRY_WIDTH    = 128,
  parameter int MAX_CFG_BURST  = 4,
  localparam int AW = (NUMBER_ENTRIES > 1) ? $clog2(NUMBER_ENTRIES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_req_i,
  input  logic                   cfg_we_i,
  input  logic [AW-1:0]          cfg_addr_i,
  input  logic [ENTRY_WIDTH-1:0] cfg_wdata_i,
  output logic                   cfg_gnt_o,
  output logic                   cfg_rvalid_o,
  output logic [ENTRY_WIDTH-1:0] cfg_rdata_o,
  input  logic                   match_req_i,
  input  logic [AW-1:0]          match_addr_i,
  output logic                   match_gnt_o,
  output logic                   match_rvalid_o,
  output logic [ENTRY_WIDTH-1:0] match_rdata_o,
  output logic                   match_restart_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AW-1:0]          sram_addr_o,
  output logic [ENTRY_WIDTH-1:0] sram_wdata_o,
  input  logic [ENTRY_WIDTH-1:0] sram_rdata_i
);

  localparam int CW = (MAX_CFG_BURST > 0) ? $clog2(MAX_CFG_BURST + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CFG_BURST);
  localparam logic [AW:0]   NUM_ENT = (AW + 1)'(NUMBER_ENTRIES);

  // Burst counter and one-deep read pipeline (valid, owner, in-range).
  logic [CW-1:0] cfg_cnt_q, cfg_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_match_q, rd_match_d;
  logic          rd_inrange_q, rd_inrange_d;
  logic          restart_q, restart_d;

  logic          cfg_gnt_s;
  logic          match_gnt_s;
  logic [AW-1:0] sel_addr_s;
  logic          in_range_s;

  // Arbitration: cfg wins ties until it has used up its burst allowance.
  always_comb begin
    cfg_gnt_s   = 1'b0;
    match_gnt_s = 1'b0;
    if (rst_i) begin
      cfg_gnt_s   = 1'b0;
      match_gnt_s = 1'b0;
    end else if (cfg_req_i && match_req_i) begin
      if (cfg_cnt_q == MAX_CNT) begin
        match_gnt_s = 1'b1;
      end else begin
        cfg_gnt_s = 1'b1;
      end
    end else if (cfg_req_i) begin
      cfg_gnt_s = 1'b1;
    end else if (match_req_i) begin
      match_gnt_s = 1'b1;
    end else begin
      cfg_gnt_s   = 1'b0;
      match_gnt_s = 1'b0;
    end
  end

  // Address mux and range check for whichever port holds the grant.
  always_comb begin
    sel_addr_s = '0;
    if (cfg_gnt_s) begin
      sel_addr_s = cfg_addr_i;
    end else if (match_gnt_s) begin
      sel_addr_s = match_addr_i;
    end else begin
      sel_addr_s = '0;
    end
    in_range_s = ({1'b0, sel_addr_s} < NUM_ENT);
  end

  // SRAM drive: only granted, in-range accesses reach the array.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if ((cfg_gnt_s || match_gnt_s) && in_range_s) begin
      sram_req_o  = 1'b1;
      sram_addr_o = sel_addr_s;
      if (cfg_gnt_s) begin
        sram_we_o    = cfg_we_i;
        sram_wdata_o = cfg_wdata_i;
      end else begin
        sram_we_o    = 1'b0;
        sram_wdata_o = '0;
      end
    end else begin
      sram_req_o = 1'b0;
    end
  end

  // Next-state: burst count, read tag and restart pulse.
  always_comb begin
    cfg_cnt_d = cfg_cnt_q;
    if (!match_req_i || match_gnt_s) begin
      cfg_cnt_d = '0;
    end else if (cfg_gnt_s && (cfg_cnt_q != MAX_CNT)) begin
      cfg_cnt_d = cfg_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cfg_cnt_d = cfg_cnt_q;
    end
    // Out-of-range reads still return rvalid; the in-range bit zeroes the data.
    rd_valid_d   = (cfg_gnt_s && !cfg_we_i) || match_gnt_s;
    rd_match_d   = match_gnt_s;
    rd_inrange_d = in_range_s;
    restart_d    = cfg_gnt_s && cfg_we_i && in_range_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_cnt_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_match_q   <= 1'b0;
      rd_inrange_q <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      cfg_cnt_q    <= cfg_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_match_q   <= rd_match_d;
      rd_inrange_q <= rd_inrange_d;
      restart_q    <= restart_d;
    end
  end

  // Output stage: the owner tag steers SRAM data; reset forces everything low,
  // which also discards a read granted in the cycle before reset.
  always_comb begin
    cfg_gnt_o       = cfg_gnt_s;
    match_gnt_o     = match_gnt_s;
    cfg_rvalid_o    = rd_valid_q && !rd_match_q && !rst_i;
    match_rvalid_o  = rd_valid_q && rd_match_q && !rst_i;
    match_restart_o = restart_q && !rst_i;
    cfg_rdata_o     = '0;
    match_rdata_o   = '0;
    if (cfg_rvalid_o && rd_inrange_q) begin
      cfg_rdata_o = sram_rdata_i;
    end else if (match_rvalid_o && rd_inrange_q) begin
      match_rdata_o = sram_rdata_i;
    end else begin
      cfg_rdata_o   = '0;
      match_rdata_o = '0;
    end
  end

endmodule

// File: tb/tb_rv_iopmp_entry_arbiter.sv
// Self-checking bench for rv_iopmp_entry_arbiter: directed vector table plus
// hand sequences for burst fairness, reset behaviour and idle quiet.
module tb_rv_iopmp_entry_arbiter;

  localparam int NE = 6;
  localparam int EW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cfg_req_i, cfg_we_i;
  logic [AW-1:0] cfg_addr_i;
  logic [EW-1:0] cfg_wdata_i;
  logic          cfg_gnt_o, cfg_rvalid_o;
  logic [EW-1:0] cfg_rdata_o;
  logic          match_req_i;
  logic [AW-1:0] match_addr_i;
  logic          match_gnt_o, match_rvalid_o, match_restart_o;
  logic [EW-1:0] match_rdata_o;
  logic          sram_req_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [EW-1:0] sram_wdata_o;
  logic [EW-1:0] sram_rdata_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_iopmp_entry_arbiter #(
    .NUMBER_ENTRIES(NE),
    .ENTRY_WIDTH(EW),
    .MAX_CFG_BURST(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .cfg_req_i(cfg_req_i),
    .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_gnt_o(cfg_gnt_o),
    .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o),
    .match_req_i(match_req_i),
    .match_addr_i(match_addr_i),
    .match_gnt_o(match_gnt_o),
    .match_rvalid_o(match_rvalid_o),
    .match_rdata_o(match_rdata_o),
    .match_restart_o(match_restart_o),
    .sram_req_o(sram_req_o),
    .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata_i)
  );

  // Behavioural single-port SRAM, read latency 1, preloaded on first edge.
  logic [EW-1:0] mem [8];
  logic          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[3]       <= 16'h00A5;
      sram_rdata_i <= 16'h0000;
      loaded       <= 1'b1;
    end else if (sram_req_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i     <= mem[sram_addr_o];
    end
  end

  typedef struct packed {
    logic          rst, creq, cwe;
    logic [AW-1:0] caddr;
    logic [EW-1:0] cwd;
    logic          mreq;
    logic [AW-1:0] maddr;
    logic          cg, mg, sreq, swe;
    logic [AW-1:0] saddr;
    logic [EW-1:0] swd;
    logic          crv;
    logic [EW-1:0] crd;
    logic          mrv;
    logic [EW-1:0] mrd;
    logic          rs;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [EW-1:0] cd, input logic mr, input logic [AW-1:0] ma);
    rst_i = r; cfg_req_i = cr; cfg_we_i = cw; cfg_addr_i = ca; cfg_wdata_i = cd;
    match_req_i = mr; match_addr_i = ma;
  endtask

  // Advance to the next cycle's drive point.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t v [15];

  initial begin
    v[0]  = '{1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h00A5, 1'b0};
    v[4]  = '{1'b0, 1'b1, 1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
    v[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0};
    v[7]  = '{1'b0, 1'b1, 1'b0, 3'd6, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[9]  = '{1'b0, 1'b1, 1'b0, 3'd5, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b1, 16'h1005, 1'b0, 16'h0000, 1'b0};
    v[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1001, 1'b0};
    v[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0};
    v[13] = '{1'b0, 1'b1, 1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    v[14] = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};

    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;

    // Vector table: one vector per cycle, all outputs checked mid-cycle.
    for (int i = 0; i < 15; i++) begin
      drive(v[i].rst, v[i].creq, v[i].cwe, v[i].caddr, v[i].cwd, v[i].mreq, v[i].maddr);
      @(negedge clk);
      chk($sformatf("v%0d cfg_gnt", i),    32'(cfg_gnt_o),       32'(v[i].cg));
      chk($sformatf("v%0d match_gnt", i),  32'(match_gnt_o),     32'(v[i].mg));
      chk($sformatf("v%0d sram_req", i),   32'(sram_req_o),      32'(v[i].sreq));
      chk($sformatf("v%0d sram_we", i),    32'(sram_we_o),       32'(v[i].swe));
      chk($sformatf("v%0d sram_addr", i),  32'(sram_addr_o),     32'(v[i].saddr));
      chk($sformatf("v%0d sram_wdata", i), 32'(sram_wdata_o),    32'(v[i].swd));
      chk($sformatf("v%0d cfg_rvalid", i), 32'(cfg_rvalid_o),    32'(v[i].crv));
      chk($sformatf("v%0d cfg_rdata", i),  32'(cfg_rdata_o),     32'(v[i].crd));
      chk($sformatf("v%0d m_rvalid", i),   32'(match_rvalid_o),  32'(v[i].mrv));
      chk($sformatf("v%0d m_rdata", i),    32'(match_rdata_o),   32'(v[i].mrd));
      chk($sformatf("v%0d restart", i),    32'(match_restart_o), 32'(v[i].rs));
      next_cycle();
    end

    // Both ports requesting: cfg x4, match, repeating.
    drive(1'b0, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b1, 3'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("burst%0d cfg_gnt", i),   32'(cfg_gnt_o),   (i % 5 != 4) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d match_gnt", i), 32'(match_gnt_o), (i % 5 == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Build cfg_cnt up to 3, reset for one cycle, then expect a full fresh burst.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("pre%0d cfg_gnt", i), 32'(cfg_gnt_o), 32'd1);
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b1, 3'd0);
    @(negedge clk);
    chk("rst cfg_gnt",    32'(cfg_gnt_o),    32'd0);
    chk("rst match_gnt",  32'(match_gnt_o),  32'd0);
    chk("rst cfg_rvalid", 32'(cfg_rvalid_o), 32'd0);
    chk("rst sram_req",   32'(sram_req_o),   32'd0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 3'd1, 16'h0000, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post%0d cfg_gnt", i),   32'(cfg_gnt_o),   (i != 4) ? 32'd1 : 32'd0);
      chk($sformatf("post%0d match_gnt", i), 32'(match_gnt_o), (i == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Match read at N, reset at N+1: its rvalid must never appear.
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3);
    @(negedge clk);
    chk("rd-rst match_gnt", 32'(match_gnt_o), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    @(negedge clk);
    chk("rd-rst m_rvalid", 32'(match_rvalid_o), 32'd0);
    chk("rd-rst m_rdata",  32'(match_rdata_o),  32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    @(negedge clk);
    chk("after-rst m_rvalid", 32'(match_rvalid_o), 32'd0);
    next_cycle();

    // Ten idle cycles: everything stays low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i),
          32'({cfg_gnt_o, match_gnt_o, cfg_rvalid_o, match_rvalid_o, match_restart_o,
               sram_req_o, sram_we_o}), 32'd0);
      chk($sformatf("idle%0d sram_bus", i), 32'({sram_addr_o, sram_wdata_o}), 32'd0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_iopmp_entry_arbiter.md
RV_IOPMP_ENTRY_ARBITER -- requirements
Module: rv_iopmp_entry_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_ENTRIES, default 8: depth of the entry SRAM.
REQ-002 SHALL have parameter ENTRY_WIDTH, default 128: entry word width in bits.
REQ-003 SHALL have parameter MAX_CFG_BURST, default 4: consecutive cfg grants allowed while match waits.
REQ-004 SHALL derive AW = max(1, $clog2(NUMBER_ENTRIES)) as the address width.
REQ-005 SHALL have one clock and a synchronous, active-high reset; the ports are clk_i and rst_i.
REQ-006 clk_i  in  1  clock; all state updates on the rising edge.
REQ-007 rst_i  in  1  synchronous reset, active-high.
REQ-008 cfg_req_i  in  1  register-map access request.
REQ-009 cfg_we_i  in  1  1 = write, 0 = read.
REQ-010 cfg_addr_i  in  AW  entry index.
REQ-011 cfg_wdata_i  in  ENTRY_WIDTH  write data.
REQ-012 cfg_gnt_o  out  1  cfg access accepted this cycle.
REQ-013 cfg_rvalid_o  out  1  cfg read data valid.
REQ-014 cfg_rdata_o  out  ENTRY_WIDTH  cfg read data.
REQ-015 match_req_i  in  1  matching-logic read request.
REQ-016 match_addr_i  in  AW  entry index.
REQ-017 match_gnt_o  out  1  match read accepted this cycle.
REQ-018 match_rvalid_o  out  1  match read data valid.
REQ-019 match_rdata_o  out  ENTRY_WIDTH  match read data.
REQ-020 match_restart_o  out  1  pulse telling matching logic that entries changed and it must restart its scan.
REQ-021 sram_req_o  out  1  single-port SRAM enable.
REQ-022 sram_we_o  out  1  SRAM write enable.
REQ-023 sram_addr_o  out  AW  SRAM address.
REQ-024 sram_wdata_o  out  ENTRY_WIDTH  SRAM write data.
REQ-025 sram_rdata_i  in  ENTRY_WIDTH  SRAM read data, valid one cycle after a read enable.

Function
REQ-026 Grants SHALL be combinational: a grant is asserted in the same cycle as its request.
- Requesters hold req, addr, we and wdata stable until granted.
REQ-027 At most one grant SHALL be asserted per cycle.
REQ-028 Grant selection SHALL be:
- only one port requesting: grant that port;
- both requesting: grant cfg unless cfg_cnt == MAX_CFG_BURST, in which case grant match.
REQ-029 cfg_cnt SHALL be a counter of width $clog2(MAX_CFG_BURST+1) with these rules:
- increments on a cfg grant while match_req_i = 1, saturating at MAX_CFG_BURST;
- clears to 0 on any match grant, or in any cycle where match_req_i = 0.
REQ-030 A granted access with addr < NUMBER_ENTRIES SHALL drive the SRAM in the grant cycle: sram_req_o = 1, sram_we_o = cfg_we_i for a cfg grant (0 for a match grant), sram_addr_o = addr, sram_wdata_o = cfg_wdata_i for a cfg grant (0 for a match grant).
REQ-031 With no grant, or with an out-of-range address, all sram_* outputs SHALL be 0.
REQ-032 A read granted in cycle N SHALL assert the owning port's rvalid for exactly cycle N+1, with its rdata = sram_rdata_i; this is read latency 1.
- The registered owner tag routes the data.
REQ-033 A non-owning port's rdata SHALL be 0.
REQ-034 An out-of-range read SHALL still return rvalid at N+1, with rdata = 0.
REQ-035 Writes SHALL produce no rvalid; an out-of-range write SHALL be granted and dropped.
REQ-036 An in-range cfg write granted in cycle N SHALL assert match_restart_o for exactly cycle N+1.
REQ-037 Back-to-back grants SHALL sustain one access per cycle, including alternating ports.
- A match read granted in cycle N+1 after a cfg write at N returns post-write data.

Reset
REQ-038 While rst_i = 1, SHALL hold all outputs at 0, clear cfg_cnt, clear the owner tag and the rvalid pipeline, and discard any in-flight read.
REQ-039 Reset asserted in the cycle after a read grant SHALL suppress that read's rvalid.
REQ-040 In the first cycle after rst_i deasserts, SHALL accept and grant requests normally.

Verification
REQ-041 Only match_req_i = 1 with addr 3, where SRAM[3] = 0xA5: match_gnt_o = 1 in cycle N; match_rvalid_o = 1 with rdata 0xA5 in N+1; cfg_rvalid_o = 0.
REQ-042 Both ports request continuously with MAX_CFG_BURST = 4: grant pattern is cfg, cfg, cfg, cfg, match, repeating.
REQ-043 cfg write of 0x1234 to addr 2 in cycle N, then match read of addr 2 in N+1: match_restart_o = 1 in N+1; match_rdata_o = 0x1234 in N+2.
REQ-044 cfg read of addr NUMBER_ENTRIES: cfg_gnt_o = 1 with sram_req_o = 0; cfg_rvalid_o = 1 with rdata 0 next cycle.
REQ-045 Match read granted at N, rst_i = 1 at N+1: match_rvalid_o = 0 at N+1; cfg_cnt = 0 after reset.
REQ-046 No requests for 10 cycles: all grants, rvalids, match_restart_o and sram_* outputs stay 0.
